// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared types and constants for the 1-to-4 frame demultiplexer.
//   state_t        : frame assembler state (FILL while collecting words,
//                    FULL while a complete frame waits for the consumer)
//   LANE_A..LANE_D : lane indices, also the bit positions in lane_valid
//   DEFAULT_WIDTH  : default word / lane width
//   FULL_MASK      : lane_valid pattern of a complete frame
// ----------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [1:0] LANE_A = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_C = 2'd2;
    localparam logic [1:0] LANE_D = 2'd3;

    localparam int         DEFAULT_WIDTH = 4;
    localparam logic [3:0] FULL_MASK     = 4'b1111;

endpackage

// File: rtl/demux_lane_reg.sv
// ----------------------------------------------------------------------------
// demux_lane_reg
// One output lane: a WIDTH-bit data register plus its "written this frame"
// valid bit.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (clears data and valid)
//   i_we     : load i_d and set valid
//   i_clr    : clear valid only; the data keeps its last value
//   i_d      : write data
//   o_q      : registered lane data
//   o_vld    : registered valid bit
// ----------------------------------------------------------------------------
module demux_lane_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_vld
);

    logic [WIDTH-1:0] r_q;
    logic             r_vld;

    // Write and clear never coincide at the top level (writes happen in
    // FILL, clears on the FULL drain); write wins if they ever did.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_vld <= 1'b0;
        end else if (i_we) begin
            r_q   <= i_d;
            r_vld <= 1'b1;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end
    end

    assign o_q   = r_q;
    assign o_vld = r_vld;

endmodule

// File: rtl/demux_4to1_frame.sv
// ----------------------------------------------------------------------------
// demux_4to1_frame
// Sequential 1-to-4 demultiplexer / frame assembler. Words accepted on a
// valid/ready handshake are steered into lanes a..d, either by addr
// (addressed mode) or in a->b->c->d order (round-robin mode). Once all four
// lanes are written the frame is presented and held until frame_ready.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in, in_valid, in_ready: word input handshake (in_ready = state decode)
//   addr                  : target lane in addressed mode
//   rr                    : 1 = round-robin, 0 = addressed (latched per frame)
//   a, b, c, d            : lane registers
//   lane_valid            : per-lane written-this-frame flags (bit0 = a)
//   frame_valid           : complete frame available
//   frame_ready           : downstream consumes the frame
//   ovr                   : sticky addressed-mode overwrite flag
// ----------------------------------------------------------------------------
module demux_4to1_frame
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       addr,
    input  logic             rr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       lane_valid,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             ovr
);

    state_t           r_state;
    logic [1:0]       r_slot;
    logic             r_mode;
    logic             r_ovr;
    logic             r_frame_valid;

    logic [WIDTH-1:0] w_q [4];
    logic [3:0]       w_vld;
    logic [3:0]       w_we;
    logic [3:0]       w_next_vld;
    logic             w_accept;
    logic             w_first;
    logic             w_mode;
    logic [1:0]       w_idx;
    logic             w_drain;

    assign w_accept = in_valid && (r_state == FILL);

    // The first beat of a frame uses rr directly; later beats use the latch,
    // so rr toggling mid-frame has no effect.
    assign w_first    = (w_vld == 4'b0000);
    assign w_mode     = w_first ? rr : r_mode;
    assign w_idx      = w_mode ? r_slot : addr;
    assign w_drain    = r_frame_valid && frame_ready;
    assign w_next_vld = w_vld | w_we;

    always_comb begin
        w_we = 4'b0000;
        if (w_accept) begin
            w_we[w_idx] = 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .i_we  (w_we[i]),
            .i_clr (w_drain),
            .i_d   (in),
            .o_q   (w_q[i]),
            .o_vld (w_vld[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FILL;
            r_slot        <= 2'd0;
            r_mode        <= 1'b0;
            r_ovr         <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_first) begin
                            r_mode <= rr;
                        end
                        if (w_mode) begin
                            r_slot <= r_slot + 2'd1;
                        end else if (w_vld[addr]) begin
                            r_ovr <= 1'b1;
                        end
                        if (w_next_vld == FULL_MASK) begin
                            r_state       <= FULL;
                            r_frame_valid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (frame_ready) begin
                        r_state       <= FILL;
                        r_frame_valid <= 1'b0;
                        r_slot        <= 2'd0;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_ready    = (r_state == FILL);
    assign a           = w_q[LANE_A];
    assign b           = w_q[LANE_B];
    assign c           = w_q[LANE_C];
    assign d           = w_q[LANE_D];
    assign lane_valid  = w_vld;
    assign frame_valid = r_frame_valid;
    assign ovr         = r_ovr;

endmodule

// File: tb/tb_demux_4to1_frame.sv
module tb_demux_4to1_frame;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   addr;
    logic         rr;
    logic [W-1:0] a, b, c, d;
    logic [3:0]   lane_valid;
    logic         frame_valid;
    logic         frame_ready;
    logic         ovr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is four slots plus a "which slots were written"
    // set; the model works on whole-frame semantics.
    int       m_lane [4];
    bit [3:0] m_vld;
    bit       m_full;
    bit       m_mode;
    bit       m_ovr;
    int       m_next_rr;

    demux_4to1_frame #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (din),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .addr        (addr),
        .rr          (rr),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .lane_valid  (lane_valid),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .ovr         (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_lane[i] = 0;
        m_vld     = 4'b0000;
        m_full    = 1'b0;
        m_mode    = 1'b0;
        m_ovr     = 1'b0;
        m_next_rr = 0;
    endfunction

    // Round-robin target = number of round-robin words already taken this
    // frame (a round-robin frame never revisits a lane).
    function automatic void model_clock();
        int  tgt;
        bit  mode;
        if (!m_full) begin
            if (in_valid) begin
                mode = (m_vld == 4'b0000) ? rr : m_mode;
                if (m_vld == 4'b0000) m_mode = rr;
                tgt = mode ? m_next_rr : int'(addr);
                if (!mode && m_vld[tgt]) m_ovr = 1'b1;
                m_lane[tgt] = int'(din);
                m_vld[tgt]  = 1'b1;
                if (mode) m_next_rr = (m_next_rr + 1) % 4;
                if (m_vld == 4'b1111) m_full = 1'b1;
            end
        end else if (frame_ready) begin
            m_full    = 1'b0;
            m_vld     = 4'b0000;
            m_next_rr = 0;
        end
    endfunction

    task automatic compare_all(input string ph);
        chk({ph, ".a"},           32'(a),           32'(m_lane[0]));
        chk({ph, ".b"},           32'(b),           32'(m_lane[1]));
        chk({ph, ".c"},           32'(c),           32'(m_lane[2]));
        chk({ph, ".d"},           32'(d),           32'(m_lane[3]));
        chk({ph, ".lane_valid"},  32'(lane_valid),  32'(m_vld));
        chk({ph, ".frame_valid"}, 32'(frame_valid), 32'(m_full));
        chk({ph, ".in_ready"},    32'(in_ready),    32'(!m_full));
        chk({ph, ".ovr"},         32'(ovr),         32'(m_ovr));
    endtask

    // Apply inputs, clock once, advance the model, compare after the edge.
    task automatic step(input string ph, input bit v, input int data,
                        input int ad, input bit r, input bit fr);
        in_valid    = v;
        din         = W'(data);
        addr        = 2'(ad);
        rr          = r;
        frame_ready = fr;
        @(posedge clk);
        model_clock();
        #1;
        compare_all(ph);
    endtask

    // Reset pulse placed between clock edges; outputs must clear at once.
    task automatic async_reset(input string ph);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all({ph, ".rst"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; in_valid = 1'b0; addr = 2'd0; rr = 1'b0; frame_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        compare_all("reset");
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // Round-robin frame 1,2,3,4
        step("rr1", 1, 1, 3, 1, 0);
        step("rr2", 1, 2, 3, 1, 0);
        step("rr3", 1, 3, 3, 1, 0);
        chk("rr.fv_before_4th", 32'(frame_valid), 32'd0);
        step("rr4", 1, 4, 3, 1, 0);
        chk("rr.frame", {16'd0, a, b, c, d}, 32'h1234);
        chk("rr.fv", 32'(frame_valid), 32'd1);
        chk("rr.in_ready_full", 32'(in_ready), 32'd0);
        step("rr_drain", 0, 0, 0, 1, 1);
        chk("rr.drain_in_ready", 32'(in_ready), 32'd1);
        chk("rr.drain_lane_valid", 32'(lane_valid), 32'd0);
        chk("rr.drain_hold", {16'd0, a, b, c, d}, 32'h1234);

        // Addressed frame: addr 3,1,0,2 data 9,8,7,6
        step("ad1", 1, 9, 3, 0, 0);
        step("ad2", 1, 8, 1, 0, 0);
        step("ad3", 1, 7, 0, 0, 0);
        step("ad4", 1, 6, 2, 0, 0);
        chk("ad.frame", {16'd0, a, b, c, d}, 32'h7869);
        chk("ad.fv", 32'(frame_valid), 32'd1);
        chk("ad.ovr", 32'(ovr), 32'd0);
        step("ad_drain", 0, 0, 0, 0, 1);

        // Overwrite: addr 0,0,1,2,3 data 1,5,2,3,4
        step("ov1", 1, 1, 0, 0, 0);
        step("ov2", 1, 5, 0, 0, 0);
        step("ov3", 1, 2, 1, 0, 0);
        step("ov4", 1, 3, 2, 0, 0);
        chk("ov.fv_after_4th", 32'(frame_valid), 32'd0);
        step("ov5", 1, 4, 3, 0, 0);
        chk("ov.fv_after_5th", 32'(frame_valid), 32'd1);
        chk("ov.a", 32'(a), 32'd5);
        chk("ov.ovr", 32'(ovr), 32'd1);

        // Backpressure with 0xF held while FULL
        for (int i = 0; i < 3; i++) begin
            step("bp", 1, 15, 2, 1, 0);
            chk("bp.a_hold", 32'(a), 32'd5);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
        end
        step("bp_drain", 1, 15, 2, 1, 1);
        step("bp_accept", 1, 15, 2, 1, 0);
        chk("bp.a_accept", 32'(a), 32'd15);
        step("bp_second", 1, 10, 2, 1, 0);

        // Reset mid-frame (two beats in), then idle: no frame may appear
        async_reset("midrst");
        for (int i = 0; i < 4; i++) begin
            step("midrst_idle", 0, 0, 0, 0, 0);
            chk("midrst.fv", 32'(frame_valid), 32'd0);
        end

        // Mode latch: first beat rr=1, then rr=0 with addr=0
        step("ml1", 1, 1, 2, 1, 0);
        step("ml2", 1, 2, 0, 0, 0);
        step("ml3", 1, 3, 0, 0, 0);
        step("ml4", 1, 4, 0, 0, 0);
        chk("ml.frame", {16'd0, a, b, c, d}, 32'h1234);
        chk("ml.ovr", 32'(ovr), 32'd0);
        chk("ml.fv", 32'(frame_valid), 32'd1);
        step("ml_drain", 0, 0, 0, 1, 1);
        step("ml_next", 1, 6, 3, 1, 0);
        chk("ml.next_to_a", 32'(lane_valid), 32'd1);

        // Randomized traffic with occasional mid-run resets
        for (int n = 0; n < 3000; n++) begin
            bit rbit;
            rbit = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 299) == 0) async_reset("rnd");
            step("rnd", ($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), rbit ? ~rr : rr, ($urandom_range(0, 9) < 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
